// File: rtl/stream_demux4_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package stream_demux4_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] ch_sel_t;

    function automatic logic [NCH-1:0] sel_onehot(input ch_sel_t sel);
        logic [NCH-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/stream_slot.sv
// One output channel: a single-entry registered buffer with a wrapping count of delivered beats.
module stream_slot
    import stream_demux4_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  din,
    input  logic          ready,
    output logic          valid,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] cnt
);

    logic          vld_q, vld_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drain;

    assign drain = vld_q & ready;

    // A load in the same cycle as a drain refills the slot, keeping one beat per cycle.
    always_comb begin
        vld_d = load | (vld_q & ~ready);
        buf_d = load ? din : buf_q;
        cnt_d = drain ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid = vld_q;
    assign dout  = buf_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 valid/ready demultiplexer: routes each input beat to the channel named by in_sel.
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NCH*W-1:0]  out_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*CW-1:0] out_cnt
);

    logic [NCH-1:0] sel_oh;
    logic [NCH-1:0] load;
    logic           accept;

    // Readiness looks only at the addressed channel so a stalled consumer never blocks the others.
    assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
    assign accept   = in_valid & in_ready;
    assign sel_oh   = sel_onehot(ch_sel_t'(in_sel));
    assign load     = sel_oh & {NCH{accept}};

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        stream_slot #(
            .W  (W),
            .CW (CW)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .din   (in_data),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .dout  (out_data[k*W +: W]),
            .cnt   (out_cnt[k*CW +: CW])
        );
    end

endmodule

// File: tb/tb_stream_demux4.sv
// Directed and random checks of stream_demux4 against a per-channel queue model.
module tb_stream_demux4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_cnt;

    int checks = 0;
    int errs   = 0;

    // Model: beats accepted but not yet delivered, per channel, plus delivery totals.
    logic [7:0] mq [4][$];
    int         del_cnt [4];

    stream_demux4 #(.W(8), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_cnt();
        logic [31:0] c;
        for (int k = 0; k < 4; k++) c[k*8 +: 8] = del_cnt[k][7:0];
        return c;
    endfunction

    // Compare on the falling edge, then advance the model by what the next rising edge will do.
    always @(negedge clk) begin
        logic       exp_ir;
        logic [3:0] exp_v;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                del_cnt[k] = 0;
            end
            chk("m_rst_valid", out_valid, 4'b0000);
            chk("m_rst_cnt", out_cnt, 32'h0);
            chk("m_rst_in_ready", in_ready, 1'b0);
        end else begin
            exp_ir = (mq[in_sel].size() == 0) || out_ready[in_sel];
            chk("m_in_ready", in_ready, exp_ir);
            for (int k = 0; k < 4; k++) exp_v[k] = (mq[k].size() != 0);
            chk("m_out_valid", out_valid, exp_v);
            for (int k = 0; k < 4; k++)
                if (mq[k].size() != 0) chk($sformatf("m_data%0d", k), out_data[k*8 +: 8], mq[k][0]);
            chk("m_cnt", out_cnt, model_cnt());
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) begin
                    void'(mq[k].pop_front());
                    del_cnt[k]++;
                end
            end
            if (in_valid && exp_ir) mq[in_sel].push_back(in_data);
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset mid-traffic with channel 2 holding a beat.
        step();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC3;
        step();
        chk("full_ch2", out_valid, 4'b0100);
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_cnt", out_cnt, 32'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            in_sel = 2'(s);
            #1;
            chk($sformatf("post_rst_ready_sel%0d", s), in_ready, 1'b1);
        end

        // Routing and one-cycle latency.
        step();
        out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
        step();
        chk("route_v0", out_valid, 4'b0001); chk("route_d0", out_data[7:0], 8'h11);
        in_sel = 2'd1; in_data = 8'h22;
        step();
        chk("route_v1", out_valid, 4'b0010); chk("route_d1", out_data[15:8], 8'h22);
        in_sel = 2'd2; in_data = 8'h33;
        step();
        chk("route_v2", out_valid, 4'b0100); chk("route_d2", out_data[23:16], 8'h33);
        in_sel = 2'd3; in_data = 8'h44;
        step();
        chk("route_v3", out_valid, 4'b1000); chk("route_d3", out_data[31:24], 8'h44);
        in_valid = 1'b0;
        step();
        chk("route_empty", out_valid, 4'b0000);
        chk("route_cnt", out_cnt, 32'h01010101);

        // Backpressure on channel 1 must not block channel 3.
        out_ready = 4'b1101; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5;
        step();
        chk("bp_v1", out_valid[1], 1'b1); chk("bp_d1", out_data[15:8], 8'hA5);
        in_data = 8'h5A;
        #1;
        chk("bp_blocked", in_ready, 1'b0);
        step();
        chk("bp_hold_d1", out_data[15:8], 8'hA5); chk("bp_hold_v1", out_valid[1], 1'b1);
        in_sel = 2'd3; in_data = 8'h77;
        #1;
        chk("bp_other_ready", in_ready, 1'b1);
        step();
        chk("bp_v3", out_valid, 4'b1010); chk("bp_d3", out_data[31:24], 8'h77);
        chk("bp_d1_still", out_data[15:8], 8'hA5);
        out_ready = 4'b1111; in_sel = 2'd1; in_data = 8'h5A;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        step();
        chk("bp_refill_v", out_valid, 4'b0010); chk("bp_refill_d1", out_data[15:8], 8'h5A);
        in_valid = 1'b0;
        step();
        chk("bp_cnt", out_cnt, 32'h02010301);

        // Back-to-back beats on one channel.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(i);
            #1;
            chk("tput_ready", in_ready, 1'b1);
            step();
            chk("tput_v0", out_valid[0], 1'b1);
            chk("tput_d0", out_data[7:0], 8'(i));
        end
        in_valid = 1'b0;
        step();
        chk("tput_cnt", out_cnt, 32'h02010311);

        // Counter wrap on channel 2 from a fresh reset.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        out_ready = 4'b1111;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_sel = 2'd2; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_cnt", out_cnt, 32'h00010000);

        // Random soak; the falling-edge compare tracks every cycle.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 4'b1111;
        step(); step(); step();
        chk("soak_drained", out_valid, 4'b0000);
        chk("soak_cnt", out_cnt, model_cnt());

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
